// File: rtl/arbitro_hierarquia.sv
// Round-robin arbiter for two requesters sharing one memory hierarchy port.
// Four-phase transaction: grant, issue, capture, respond; plus hit/miss stats.
module arbitro_hierarquia #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_a,
   input  logic              req_b,
   input  logic              we_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              ack_a,
   output logic              ack_b,
   output logic [DATA_W-1:0] rdata,
   output logic              resp_hit_l1,
   output logic              resp_hit_l2,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic              mem_hit_l1,
   input  logic              mem_hit_l2,
   input  logic              clr_stats,
   output logic [CNT_W-1:0]  cnt_hit_l1,
   output logic [CNT_W-1:0]  cnt_hit_l2,
   output logic [CNT_W-1:0]  cnt_miss
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } state_t;

   state_t            state;
   logic              ptr_b;
   logic              sel_b;
   logic              grant_b;
   logic              we_sel;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] wdata_sel;

   assign busy = (state != IDLE);

   // Pick the winner: pointer breaks ties, a lone requester always wins.
   always_comb begin
      grant_b   = 1'b0;
      we_sel    = we_a;
      addr_sel  = addr_a;
      wdata_sel = wdata_a;
      if (req_a && req_b) begin
         grant_b = ptr_b;
      end else begin
         grant_b = req_b;
      end
      if (grant_b) begin
         we_sel    = we_b;
         addr_sel  = addr_b;
         wdata_sel = wdata_b;
      end
   end

   // Transaction sequencer; the granted request is latched into the mem_* regs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         ptr_b          <= 1'b0;
         sel_b          <= 1'b0;
         ack_a          <= 1'b0;
         ack_b          <= 1'b0;
         rdata          <= '0;
         resp_hit_l1    <= 1'b0;
         resp_hit_l2    <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
      end else begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         ack_a     <= 1'b0;
         ack_b     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_a || req_b) begin
                  state          <= ISSUE;
                  sel_b          <= grant_b;
                  ptr_b          <= ~grant_b;
                  mem_address    <= addr_sel;
                  mem_write_data <= wdata_sel;
                  mem_read       <= ~we_sel;
                  mem_write      <= we_sel;
               end
            end
            ISSUE: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               state       <= RESP;
               rdata       <= mem_read_data;
               resp_hit_l1 <= mem_hit_l1;
               resp_hit_l2 <= mem_hit_l2;
               ack_a       <= ~sel_b;
               ack_b       <= sel_b;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Saturating hit/miss statistics; clear beats a same-cycle increment.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_hit_l1 <= '0;
         cnt_hit_l2 <= '0;
         cnt_miss   <= '0;
      end else if (clr_stats) begin
         cnt_hit_l1 <= '0;
         cnt_hit_l2 <= '0;
         cnt_miss   <= '0;
      end else if (state == CAPTURE) begin
         if (mem_hit_l1) begin
            if (cnt_hit_l1 != '1) cnt_hit_l1 <= cnt_hit_l1 + CNT_W'(1);
         end else if (mem_hit_l2) begin
            if (cnt_hit_l2 != '1) cnt_hit_l2 <= cnt_hit_l2 + CNT_W'(1);
         end else begin
            if (cnt_miss != '1) cnt_miss <= cnt_miss + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_arbitro_hierarquia.sv
// Scoreboard bench for arbitro_hierarquia: transaction-level model of
// arbitration, latency and statistics, with a toy memory hierarchy.
module tb_arbitro_hierarquia;
   localparam int AW = 6;
   localparam int DW = 16;
   localparam int CW = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clock = 0;
   logic          reset = 1;
   logic          req_a = 0, req_b = 0, we_a = 0, we_b = 0;
   logic [AW-1:0] addr_a = 0, addr_b = 0;
   logic [DW-1:0] wdata_a = 0, wdata_b = 0;
   logic          ack_a, ack_b, resp_hit_l1, resp_hit_l2, busy;
   logic [DW-1:0] rdata, mem_write_data;
   logic [AW-1:0] mem_address;
   logic          mem_read, mem_write;
   logic [DW-1:0] mem_read_data = 0;
   logic          mem_hit_l1 = 0, mem_hit_l2 = 0;
   logic          clr_stats = 0;
   logic [CW-1:0] cnt_hit_l1, cnt_hit_l2, cnt_miss;

   arbitro_hierarquia #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset),
      .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
      .addr_a(addr_a), .addr_b(addr_b),
      .wdata_a(wdata_a), .wdata_b(wdata_b),
      .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata),
      .resp_hit_l1(resp_hit_l1), .resp_hit_l2(resp_hit_l2), .busy(busy),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_read_data(mem_read_data),
      .mem_hit_l1(mem_hit_l1), .mem_hit_l2(mem_hit_l2),
      .clr_stats(clr_stats),
      .cnt_hit_l1(cnt_hit_l1), .cnt_hit_l2(cnt_hit_l2), .cnt_miss(cnt_miss)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          b;
      bit          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int          e;
   } iss_t;

   typedef struct {
      bit          b;
      logic [DW-1:0] d;
      bit          h1;
      bit          h2;
      int          e;
   } rsp_t;

   iss_t iq[$];
   rsp_t rq[$];
   iss_t xi;
   rsp_t xr;

   int nvec = 0, nerr = 0;
   int cyc = 0, free_e = 0, pend = 0;
   int bz_from = 0, bz_to = -1;
   int m_h1 = 0, m_h2 = 0, m_ms = 0;
   bit p_h1 = 0, p_h2 = 0;
   bit mptr = 0;
   bit started = 0;
   bit rand_resp = 0;
   logic [DW-1:0] f_data = 0;
   bit f_h1 = 0, f_h2 = 0;

   task automatic chk(string nm, longint act, longint exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int sat(int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   // Statistics model: counts land on the edge ending the capture cycle.
   always @(posedge clock) begin
      cyc++;
      if (reset) begin
         if (pend == 1) begin
            pend = 2;
         end else if (pend == 2) begin
            pend = 0;
            if (p_h1) m_h1 = sat(m_h1);
            else if (p_h2) m_h2 = sat(m_h2);
            else m_ms = sat(m_ms);
         end
         if (clr_stats) begin
            m_h1 = 0;
            m_h2 = 0;
            m_ms = 0;
         end
      end
   end

   // Monitor: checks issue, ack and counters; plays the memory hierarchy.
   always @(negedge clock) begin
      if (reset && started) begin
         chk("busy", busy, (cyc >= bz_from && cyc <= bz_to));
         if (mem_read || mem_write) begin
            if (iq.size() == 0) begin
               chk("issue_unexpected", 1, 0);
            end else begin
               xi = iq.pop_front();
               chk("issue_cycle", cyc, xi.e);
               chk("mem_write", mem_write, xi.we);
               chk("mem_read", mem_read, !xi.we);
               chk("mem_address", mem_address, xi.a);
               chk("mem_write_data", mem_write_data, xi.d);
               if (rand_resp) begin
                  xr.d  = DW'($urandom);
                  xr.h1 = ($urandom_range(0, 2) == 0);
                  xr.h2 = $urandom_range(0, 1);
               end else begin
                  xr.d  = f_data;
                  xr.h1 = f_h1;
                  xr.h2 = f_h2;
               end
               xr.b = xi.b;
               xr.e = xi.e + 2;
               mem_read_data = xr.d;
               mem_hit_l1 = xr.h1;
               mem_hit_l2 = xr.h2;
               rq.push_back(xr);
               p_h1 = xr.h1;
               p_h2 = xr.h2;
               pend = 1;
            end
         end
         if (ack_a || ack_b) begin
            if (rq.size() == 0) begin
               chk("ack_unexpected", 1, 0);
            end else begin
               xr = rq.pop_front();
               chk("ack_cycle", cyc, xr.e);
               chk("ack_a", ack_a, !xr.b);
               chk("ack_b", ack_b, xr.b);
               chk("rdata", rdata, xr.d);
               chk("resp_hit_l1", resp_hit_l1, xr.h1);
               chk("resp_hit_l2", resp_hit_l2, xr.h2);
            end
         end
         chk("cnt_hit_l1", cnt_hit_l1, m_h1);
         chk("cnt_hit_l2", cnt_hit_l2, m_h2);
         chk("cnt_miss", cnt_miss, m_ms);
      end
   end

   task automatic drive(bit ra, bit wa, logic [AW-1:0] aa, logic [DW-1:0] da,
                        bit rb, bit wb, logic [AW-1:0] ab, logic [DW-1:0] db,
                        bit clr);
      bit g;
      iss_t t;
      @(negedge clock);
      req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
      req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
      clr_stats = clr;
      if (reset && (cyc + 1 >= free_e) && (ra || rb)) begin
         g = (ra && rb) ? mptr : rb;
         t.b  = g;
         t.we = g ? wb : wa;
         t.a  = g ? ab : aa;
         t.d  = g ? db : da;
         t.e  = cyc + 1;
         iq.push_back(t);
         mptr    = !g;
         free_e  = cyc + 5;
         bz_from = cyc + 1;
         bz_to   = cyc + 3;
      end
   endtask

   task automatic idle(int n);
      repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset(int hold);
      @(negedge clock);
      #2;
      reset = 0;
      iq.delete();
      rq.delete();
      pend = 0;
      m_h1 = 0; m_h2 = 0; m_ms = 0;
      mptr = 0;
      bz_to = -1;
      #1;
      if (started) begin
         chk("rst_ack_a", ack_a, 0);
         chk("rst_ack_b", ack_b, 0);
         chk("rst_mem_read", mem_read, 0);
         chk("rst_mem_write", mem_write, 0);
         chk("rst_busy", busy, 0);
         chk("rst_rdata", rdata, 0);
         chk("rst_mem_address", mem_address, 0);
         chk("rst_mem_write_data", mem_write_data, 0);
         chk("rst_hit_l1", resp_hit_l1, 0);
         chk("rst_hit_l2", resp_hit_l2, 0);
         chk("rst_cnt_hit_l1", cnt_hit_l1, 0);
         chk("rst_cnt_hit_l2", cnt_hit_l2, 0);
         chk("rst_cnt_miss", cnt_miss, 0);
      end
      repeat (hold) @(negedge clock);
      #2;
      reset = 1;
      free_e = cyc + 1;
      started = 1;
   endtask

   initial begin
      do_reset(2);
      // first reset again with checks enabled
      do_reset(1);

      // single write miss from A
      f_data = 16'h1234; f_h1 = 0; f_h2 = 0;
      drive(1, 1, 1, 2, 0, 0, 0, 0, 0);
      idle(6);
      chk("single_miss_cnt", cnt_miss, 1);

      // both requesting after reset: A, B, A alternation
      do_reset(1);
      repeat (12) drive(1, 0, 3, 0, 1, 0, 4, 0, 0);
      idle(6);

      // lone B read with L1 hit
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      f_data = 16'd4; f_h1 = 1; f_h2 = 0;
      drive(0, 0, 0, 0, 1, 0, 18, 0, 0);
      idle(6);
      chk("b_read_rdata", rdata, 4);
      chk("b_read_hit_l1", resp_hit_l1, 1);
      chk("b_read_cnt_l1", cnt_hit_l1, 1);

      // reset during capture abandons the transaction
      f_h1 = 0;
      drive(1, 0, 7, 0, 0, 0, 0, 0, 0);
      idle(1);
      do_reset(2);
      idle(2);
      drive(1, 0, 9, 0, 0, 0, 0, 0, 0);
      idle(6);

      // request dropped and address changed after grant
      drive(1, 0, 5, 16'h55, 0, 0, 0, 0, 0);
      drive(0, 0, 9, 16'h99, 0, 0, 0, 0, 0);
      idle(6);

      // saturation after 256 misses, then clear during capture
      f_h1 = 0; f_h2 = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(2);
      repeat (256 * 4) drive(1, 0, 2, 0, 0, 0, 0, 0, 0);
      idle(6);
      chk("miss_saturated", cnt_miss, 255);
      drive(1, 0, 2, 0, 0, 0, 0, 0, 0);
      idle(6);
      chk("miss_held", cnt_miss, 255);
      f_h1 = 1;
      drive(1, 0, 2, 0, 0, 0, 0, 0, 0);
      idle(1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(4);
      chk("clr_cnt_l1", cnt_hit_l1, 0);
      chk("clr_cnt_l2", cnt_hit_l2, 0);
      chk("clr_cnt_miss", cnt_miss, 0);

      // randomized traffic
      rand_resp = 1;
      repeat (800) begin
         drive($urandom_range(0, 1), $urandom_range(0, 1), AW'($urandom),
               DW'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
               AW'($urandom), DW'($urandom), ($urandom_range(0, 39) == 0));
      end
      idle(8);
      chk("issue_queue_drained", iq.size(), 0);
      chk("resp_queue_drained", rq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/arbitro_hierarquia.md
ARBITRO_HIERARQUIA -- requirements
Module: arbitro_hierarquia

Interface
REQ-001 Parameter ADDR_W, default 6, address width of the memory hierarchy.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter CNT_W, default 8, width of each statistics counter.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-006 req_a, req_b  input  1 each  access request from requester A / B.
REQ-007 we_a, we_b  input  1 each  1 = write, 0 = read, for the matching requester.
REQ-008 addr_a, addr_b  input  ADDR_W each  request address.
REQ-009 wdata_a, wdata_b  input  DATA_W each  write data.
REQ-010 ack_a, ack_b  output  1 each  one-cycle completion pulse to A / B.
REQ-011 rdata  output  DATA_W  data returned with the ack.
REQ-012 resp_hit_l1, resp_hit_l2  output  1 each  hit flags returned with the ack.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 mem_address  output  ADDR_W; mem_write_data  output  DATA_W; mem_read, mem_write  output  1 -- drive the hierarchy.
REQ-015 mem_read_data  input  DATA_W; mem_hit_l1, mem_hit_l2  input  1 -- results from the hierarchy.
REQ-016 clr_stats  input  1  synchronous clear of the statistics counters.
REQ-017 cnt_hit_l1, cnt_hit_l2, cnt_miss  output  CNT_W each  statistics counters.

Function
REQ-018 FSM states: IDLE, ISSUE, CAPTURE, RESP; transitions IDLE->ISSUE (a request is granted), ISSUE->CAPTURE, CAPTURE->RESP, RESP->IDLE, all unconditional except the first.
REQ-019 In IDLE with any req high, the arbiter shall grant one requester and latch its we/addr/wdata; with no req it shall stay in IDLE.
REQ-020 Arbitration: round-robin priority pointer; pointer = A after reset; when both req high the pointer holder wins; after each granted transaction the pointer moves to the other requester.
REQ-021 With a single requester active, it shall be granted regardless of the pointer.
REQ-022 ISSUE: mem_address/mem_write_data = latched values; exactly one of mem_read/mem_write high, per latched we, for exactly this one cycle.
REQ-023 Outside ISSUE, mem_read = mem_write = 0; mem_address/mem_write_data hold their last driven values.
REQ-024 CAPTURE: register mem_read_data, mem_hit_l1, mem_hit_l2 at the end of the cycle.
REQ-025 RESP: the granted requester's ack is high for exactly one cycle; rdata and resp_hit_* present the captured values; the other ack stays 0.
REQ-026 Latency: req sampled in IDLE at cycle t -> ISSUE t+1, CAPTURE t+2, ack at t+3; earliest next grant at t+4.
REQ-027 rdata and resp_hit_* hold their values until the next RESP; on writes rdata carries whatever the hierarchy returned.
REQ-028 Requests are latched at grant; deasserting req or changing addr/wdata afterwards does not affect the transaction, and the ack is still issued.
REQ-029 A req still high in the IDLE cycle after its ack is treated as a new request.
REQ-030 Statistics, updated at the end of CAPTURE: mem_hit_l1=1 -> cnt_hit_l1+1; else mem_hit_l2=1 -> cnt_hit_l2+1; else cnt_miss+1.
REQ-031 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-032 clr_stats has priority over a simultaneous increment; counters read 0 the next cycle.

Reset
REQ-033 reset low asynchronously forces: state IDLE, pointer A, all ack/mem_read/mem_write/busy 0, rdata/mem_address/mem_write_data/resp_hit_*/counters 0.
REQ-034 A transaction interrupted by reset is abandoned: no ack is ever issued for it; operation resumes from IDLE on the first edge after reset release.

Verification
REQ-035 req_a=1, we_a=1, addr_a=1, wdata_a=2, single cycle -> mem_write=1 with mem_address=1, mem_write_data=2 one cycle later; ack_a at t+3; with hierarchy returning hit_l1=0, hit_l2=0, cnt_miss=1.
REQ-036 req_a and req_b high together after reset, both held -> A acked at t+3, B acked at t+7, then A again at t+11 (alternation).
REQ-037 req_b alone, read addr 18, hierarchy returns data 4, hit_l1=1 -> ack_b, rdata=4, resp_hit_l1=1, cnt_hit_l1=1, ack_a never asserted.
REQ-038 Reset pulsed low during CAPTURE -> all outputs 0 immediately, no ack follows, counters 0, next request completes normally.
REQ-039 256 consecutive misses with CNT_W=8 -> cnt_miss=255 held; then clr_stats=1 coincident with a CAPTURE -> all counters 0.
REQ-040 req_a dropped after grant cycle and addr_a changed -> transaction completes with the originally latched address and ack_a still pulses once.
